// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter feeding one UART transmitter from four byte requesters.
// Optional UART_ARB_LOCK_EN adds req_lock so an owner can keep the transmitter for back-to-back bytes.
module uart_tx_arbiter #(
    parameter int unsigned GAP_CYCLES = 16
) (
    input  logic        CLOCK_50,
    input  logic        RESET_N,
    input  logic [3:0]  req_valid,
    input  logic [31:0] req_data,
    output logic [3:0]  req_ready,
    output logic [7:0]  tx_data,
    output logic        tx_start,
    input  logic        tx_busy,
    output logic [1:0]  grant_id,
    output logic        arb_idle
`ifdef UART_ARB_LOCK_EN
    ,
    input  logic [3:0]  req_lock
`endif
);

    localparam int unsigned NREQ  = 4;
    localparam int unsigned CNT_W = (GAP_CYCLES == 0) ? 1 : $clog2(GAP_CYCLES + 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT_BUSY,
        ST_WAIT_DONE,
        ST_GAP
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [1:0]         r_last_grant;
    logic [CNT_W-1:0]   r_gap_cnt;
    logic               r_lock_hold;

    logic               w_rr_found;
    logic [1:0]         w_rr_winner;
    logic [1:0]         w_winner;
    logic               w_lock_sel;
    logic               w_lock_cap;
    logic               w_grant;
    logic               w_to_idle;

    logic [3:0]         w_ready_nxt;
    logic [7:0]         w_data_nxt;
    logic               w_start_nxt;
    logic [1:0]         w_gid_nxt;
    logic [1:0]         w_last_nxt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic               w_lock_nxt;

`ifdef UART_ARB_LOCK_EN
    assign w_lock_cap = req_lock[r_grant_id_c()] & req_valid[r_grant_id_c()];
    function automatic logic [1:0] r_grant_id_c();
        return grant_id;
    endfunction
`else
    assign w_lock_cap = 1'b0;
`endif

    // First valid requester searching upward from the one after the last grant
    always_comb begin
        w_rr_found  = 1'b0;
        w_rr_winner = r_last_grant;
        for (int unsigned k = 1; k <= NREQ; k++) begin
            if (!w_rr_found && req_valid[2'(r_last_grant + 2'(k))]) begin
                w_rr_found  = 1'b1;
                w_rr_winner = 2'(r_last_grant + 2'(k));
            end
        end
    end

    assign w_lock_sel = r_lock_hold & req_valid[grant_id];
    assign w_winner   = w_lock_sel ? grant_id : w_rr_winner;
    assign w_grant    = (r_state == ST_IDLE) && (|req_valid) && !tx_busy;
    assign w_to_idle  = (r_state != ST_IDLE) && (w_state_nxt == ST_IDLE);

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) r_state <= ST_IDLE;
        else          r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:      if (w_grant) w_state_nxt = ST_ISSUE;
            ST_ISSUE:     w_state_nxt = ST_WAIT_BUSY;
            ST_WAIT_BUSY: if (tx_busy) w_state_nxt = ST_WAIT_DONE;
            ST_WAIT_DONE: if (!tx_busy) w_state_nxt = (GAP_CYCLES > 0) ? ST_GAP : ST_IDLE;
            ST_GAP:       if (r_gap_cnt == CNT_W'(GAP_CYCLES - 1)) w_state_nxt = ST_IDLE;
            default:      w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        w_ready_nxt = 4'b0000;
        w_start_nxt = 1'b0;
        w_data_nxt  = tx_data;
        w_gid_nxt   = grant_id;
        w_last_nxt  = r_last_grant;
        w_cnt_nxt   = r_gap_cnt;
        w_lock_nxt  = r_lock_hold;
        case (r_state)
            ST_IDLE: begin
                if (w_grant) begin
                    w_ready_nxt = 4'b0001 << w_winner;
                    w_data_nxt  = req_data[{w_winner, 3'b000} +: 8];
                    w_gid_nxt   = w_winner;
                    w_lock_nxt  = 1'b0;
                    // A locked re-grant leaves the rotation pointer where it was
                    if (!w_lock_sel) w_last_nxt = w_winner;
                end
            end
            ST_ISSUE:     w_start_nxt = 1'b1;
            ST_GAP:       w_cnt_nxt   = r_gap_cnt + CNT_W'(1);
            default: ;
        endcase
        if (w_state_nxt == ST_GAP && r_state != ST_GAP) w_cnt_nxt = '0;
        if (w_to_idle) begin
            w_cnt_nxt  = '0;
            w_lock_nxt = w_lock_cap;
        end
    end

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            req_ready    <= 4'b0000;
            tx_start     <= 1'b0;
            tx_data      <= 8'h00;
            grant_id     <= 2'd0;
            arb_idle     <= 1'b1;
            r_last_grant <= 2'd3;
            r_gap_cnt    <= '0;
            r_lock_hold  <= 1'b0;
        end else begin
            req_ready    <= w_ready_nxt;
            tx_start     <= w_start_nxt;
            tx_data      <= w_data_nxt;
            grant_id     <= w_gid_nxt;
            arb_idle     <= (w_state_nxt == ST_IDLE);
            r_last_grant <= w_last_nxt;
            r_gap_cnt    <= w_cnt_nxt;
            r_lock_hold  <= w_lock_nxt;
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: latency, round-robin table, spacing, busy hold-off, async reset.
// Define UART_ARB_LOCK_EN in both files to also exercise the lock sequence.
module tb_uart_tx_arbiter;

    localparam int unsigned GAP     = 16;
    localparam int          BUSY_LEN = 10;
    localparam int          SPACING  = BUSY_LEN + GAP + 3;
    localparam int          NVEC     = 9;

    logic        CLOCK_50 = 1'b0;
    logic        RESET_N  = 1'b0;
    logic [3:0]  req_valid = 4'b0;
    logic [31:0] req_data  = 32'h0;
    logic [3:0]  req_ready;
    logic [7:0]  tx_data;
    logic        tx_start;
    logic        tx_busy   = 1'b0;
    logic [1:0]  grant_id;
    logic        arb_idle;
`ifdef UART_ARB_LOCK_EN
    logic [3:0]  req_lock  = 4'b0;
`endif

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   busy_cnt = 0;
    int   last_start = 0;
    logic force_busy = 1'b0;
    bit   ok;

    typedef struct {
        logic [3:0]  valid;
        logic [31:0] data;
        logic [1:0]  exp_gid;
        logic [7:0]  exp_byte;
    } vec_t;

    vec_t vecs [NVEC];

    uart_tx_arbiter #(.GAP_CYCLES(GAP)) dut (
        .CLOCK_50  (CLOCK_50),
        .RESET_N   (RESET_N),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .tx_data   (tx_data),
        .tx_start  (tx_start),
        .tx_busy   (tx_busy),
        .grant_id  (grant_id),
        .arb_idle  (arb_idle)
`ifdef UART_ARB_LOCK_EN
        ,
        .req_lock  (req_lock)
`endif
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    always @(posedge CLOCK_50) cyc <= cyc + 1;

    // Transmitter model: busy for BUSY_LEN sampling edges after each start pulse
    always @(negedge CLOCK_50) begin
        if (tx_start) busy_cnt = BUSY_LEN;
        else if (busy_cnt > 0) busy_cnt = busy_cnt - 1;
        tx_busy = force_busy || (busy_cnt != 0);
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic wait_ready(input string name, output bit got);
        got = 1'b0;
        for (int n = 0; n < 200; n++) begin
            @(negedge CLOCK_50);
            if (req_ready != 4'b0) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL %s actual=no_req_ready required=req_ready_pulse", name);
        end
    endtask

    task automatic wait_idle(input string name);
        bit seen;
        seen = 1'b0;
        for (int n = 0; n < 200; n++) begin
            @(negedge CLOCK_50);
            if (arb_idle) begin
                seen = 1'b1;
                break;
            end
        end
        chk(name, 32'(seen), 32'd1);
    endtask

    initial begin
        vecs[0] = '{4'b1111, 32'h43322110, 2'd0, 8'h10};
        vecs[1] = '{4'b1111, 32'h43322154, 2'd1, 8'h21};
        vecs[2] = '{4'b1111, 32'h43326554, 2'd2, 8'h32};
        vecs[3] = '{4'b1111, 32'h43766554, 2'd3, 8'h43};
        vecs[4] = '{4'b1111, 32'h87766554, 2'd0, 8'h54};
        vecs[5] = '{4'b1010, 32'hA3B2C1D0, 2'd1, 8'hC1};
        vecs[6] = '{4'b1001, 32'hA3B2C1D0, 2'd3, 8'hA3};
        vecs[7] = '{4'b0101, 32'hA3B2C1D0, 2'd0, 8'hD0};
        vecs[8] = '{4'b0100, 32'hA3B2C1D0, 2'd2, 8'hB2};

        // Reset values
        repeat (3) @(negedge CLOCK_50);
        chk("rst req_ready", 32'(req_ready), 32'h0);
        chk("rst tx_start", 32'(tx_start), 32'h0);
        chk("rst tx_data", 32'(tx_data), 32'h00);
        chk("rst grant_id", 32'(grant_id), 32'h0);
        chk("rst arb_idle", 32'(arb_idle), 32'h1);
        RESET_N = 1'b1;

        // Single byte latency: ready at N+1, start at N+2
        @(negedge CLOCK_50);
        req_valid = 4'b0001;
        req_data  = 32'h00000055;
        @(negedge CLOCK_50);
        chk("lat ready N+1", 32'(req_ready), 32'h1);
        chk("lat gid", 32'(grant_id), 32'h0);
        chk("lat data", 32'(tx_data), 32'h55);
        chk("lat start low N+1", 32'(tx_start), 32'h0);
        chk("lat arb_idle", 32'(arb_idle), 32'h0);
        req_valid = 4'b0000;
        req_data  = 32'h0;
        @(negedge CLOCK_50);
        chk("lat start N+2", 32'(tx_start), 32'h1);
        chk("lat start data", 32'(tx_data), 32'h55);
        chk("lat ready cleared", 32'(req_ready), 32'h0);
        @(negedge CLOCK_50);
        chk("lat start one cycle", 32'(tx_start), 32'h0);

        // Asynchronous reset while the byte is on the wire
        chk("wd busy before reset", 32'(tx_busy), 32'h1);
        RESET_N = 1'b0;
        #1;
        chk("arst tx_data", 32'(tx_data), 32'h00);
        chk("arst arb_idle", 32'(arb_idle), 32'h1);
        chk("arst grant_id", 32'(grant_id), 32'h0);
        chk("arst tx_start", 32'(tx_start), 32'h0);
        chk("arst req_ready", 32'(req_ready), 32'h0);
        repeat (2) @(negedge CLOCK_50);
        RESET_N   = 1'b1;
        req_valid = vecs[0].valid;
        req_data  = vecs[0].data;

        // Round-robin table, each requester refilled as it is accepted
        for (int i = 0; i < NVEC; i++) begin
            wait_ready($sformatf("vec%0d wait", i), ok);
            if (!ok) break;
            chk($sformatf("vec%0d ready", i), 32'(req_ready), 32'(4'b0001 << vecs[i].exp_gid));
            chk($sformatf("vec%0d gid", i), 32'(grant_id), 32'(vecs[i].exp_gid));
            chk($sformatf("vec%0d data", i), 32'(tx_data), 32'(vecs[i].exp_byte));
            if (i + 1 < NVEC) begin
                req_valid = vecs[i + 1].valid;
                req_data  = vecs[i + 1].data;
            end else begin
                req_valid = 4'b0000;
                req_data  = 32'h0;
            end
            @(negedge CLOCK_50);
            chk($sformatf("vec%0d start", i), 32'(tx_start), 32'h1);
            chk($sformatf("vec%0d start data", i), 32'(tx_data), 32'(vecs[i].exp_byte));
            if (i > 0) chk($sformatf("vec%0d spacing", i), 32'(cyc - last_start), 32'(SPACING));
            last_start = cyc;
        end
        wait_idle("idle after table");

        // Busy transmitter holds off a grant in IDLE
        force_busy = 1'b1;
        @(negedge CLOCK_50);
        req_valid = 4'b0010;
        req_data  = 32'h00009900;
        for (int n = 0; n < 5; n++) begin
            @(negedge CLOCK_50);
            chk($sformatf("busy hold ready c%0d", n), 32'(req_ready), 32'h0);
            chk($sformatf("busy hold idle c%0d", n), 32'(arb_idle), 32'h1);
        end
        force_busy = 1'b0;
        wait_ready("busy release wait", ok);
        if (ok) begin
            chk("busy release ready", 32'(req_ready), 32'h2);
            chk("busy release gid", 32'(grant_id), 32'h1);
            chk("busy release data", 32'(tx_data), 32'h99);
        end
        req_valid = 4'b0000;
        wait_idle("idle after busy test");

`ifdef UART_ARB_LOCK_EN
        // Locked owner keeps the transmitter until it drops the lock
        req_lock  = 4'b0001;
        req_valid = 4'b0011;
        req_data  = 32'h0000BBAA;
        for (int n = 0; n < 3; n++) begin
            wait_ready($sformatf("lock%0d wait", n), ok);
            if (!ok) break;
            chk($sformatf("lock%0d gid", n), 32'(grant_id), 32'h0);
            chk($sformatf("lock%0d data", n), 32'(tx_data), 32'hAA);
            if (n == 2) req_lock = 4'b0000;
        end
        wait_ready("unlock wait", ok);
        if (ok) begin
            chk("unlock gid", 32'(grant_id), 32'h1);
            chk("unlock data", 32'(tx_data), 32'hBB);
        end
        req_valid = 4'b0000;
        wait_idle("idle after lock test");
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
